// File: rtl/ula_escalonador.sv
// Two-requester arbiter/sequencer for the ula datapath: IDLE -> ISSUE -> EXEC -> CAPT.
// Define ULA_ESC_PRIO_FIXA_EN for fixed priority (requester 0 wins); default is round-robin.
module ula_escalonador #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [N-1:0] ula_a,
    output logic [N-1:0] ula_b,
    output logic [2:0]   ula_op,
    input  logic [N-1:0] ula_s,
    input  logic         ula_flag,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [N-1:0] resp_s,
    output logic         resp_flag,
    output logic         busy
);
    localparam int unsigned OPW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, CAPT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   ula_a_q, ula_a_d;
    logic [N-1:0]   ula_b_q, ula_b_d;
    logic [OPW-1:0] ula_op_q, ula_op_d;
    logic           id_q, id_d;
    logic           flag_q, flag_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_id_q, resp_id_d;
    logic [N-1:0]   resp_s_q, resp_s_d;
    logic           resp_flag_q, resp_flag_d;
    logic           busy_q, busy_d;
    logic           grant0_c, grant1_c, idle_c;
`ifndef ULA_ESC_PRIO_FIXA_EN
    logic           rr_q, rr_d;
`endif

    // Grant selection; readies only exist in IDLE and never during reset.
    always_comb begin
`ifdef ULA_ESC_PRIO_FIXA_EN
        grant0_c = req0_valid;
        grant1_c = req1_valid && !req0_valid;
`else
        grant0_c = req0_valid && (!req1_valid || !rr_q);
        grant1_c = req1_valid && (!req0_valid || rr_q);
`endif
        idle_c     = (state_q == IDLE) && !rst;
        req0_ready = idle_c && grant0_c;
        req1_ready = idle_c && grant1_c;
    end

    always_comb begin
        state_d      = state_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_op_d     = ula_op_q;
        id_d         = id_q;
        flag_d       = flag_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_s_d     = resp_s_q;
        resp_flag_d  = resp_flag_q;
`ifndef ULA_ESC_PRIO_FIXA_EN
        rr_d         = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d  = ISSUE;
                    id_d     = req1_ready;
                    ula_a_d  = req1_ready ? req1_a  : req0_a;
                    ula_b_d  = req1_ready ? req1_b  : req0_b;
                    ula_op_d = req1_ready ? req1_op : req0_op;
`ifndef ULA_ESC_PRIO_FIXA_EN
                    rr_d     = req0_ready;
`endif
                end
            end
            ISSUE: state_d = EXEC;
            EXEC: begin
                flag_d  = ula_flag;
                state_d = CAPT;
            end
            CAPT: begin
                // Flag is only meaningful for add/sub (opcodes 000, 001).
                resp_s_d     = ula_s;
                resp_flag_d  = flag_q && (ula_op_q[2:1] == 2'b00);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_op_q     <= '0;
            id_q         <= 1'b0;
            flag_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_s_q     <= '0;
            resp_flag_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifndef ULA_ESC_PRIO_FIXA_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_op_q     <= ula_op_d;
            id_q         <= id_d;
            flag_q       <= flag_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_s_q     <= resp_s_d;
            resp_flag_q  <= resp_flag_d;
            busy_q       <= busy_d;
`ifndef ULA_ESC_PRIO_FIXA_EN
            rr_q         <= rr_d;
`endif
        end
    end

    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_op     = ula_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign resp_flag  = resp_flag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ula_escalonador.sv
// Directed bench for ula_escalonador with a small registered ALU model attached.
module tb_ula_escalonador;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [N-1:0] ula_a, ula_b, ula_s;
    logic [2:0]   ula_op;
    logic         ula_flag;
    logic         resp_valid, resp_id, resp_flag, busy;
    logic [N-1:0] resp_s;

    int total = 0;
    int bad   = 0;

    ula_escalonador #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
        .ula_s(ula_s), .ula_flag(ula_flag),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_s(resp_s), .resp_flag(resp_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: input registers, opcode decoded live, output register.
    logic [N-1:0] ar = '0, br = '0, sr = '0;
    logic [N:0]   sum_c;
    function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return ~a;
            3'b110: return (a == b) ? N'(1) : N'(0);
            default: return (a != b) ? N'(1) : N'(0);
        endcase
    endfunction
    always @(posedge clk) begin
        ar <= ula_a;
        br <= ula_b;
        sr <= alu_f(ar, br, ula_op);
    end
    assign sum_c    = {1'b0, ar} + {1'b0, br};
    assign ula_flag = (ula_op == 3'b001) ? (ar < br) : sum_c[N];
    assign ula_s    = sr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted op from requester id, checked through its 4-cycle latency.
    task automatic do_op(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] op, input logic [N-1:0] exp_s, input logic exp_f);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk("ready_sel", 32'(id ? req1_ready : req0_ready), 32'd1);
        chk("ready_oth", 32'(id ? req0_ready : req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("ula_op_hold", 32'(ula_op), 32'(op));
            chk("ula_a_hold", 32'(ula_a), 32'(a));
            chk("no_early_resp", 32'(resp_valid), 32'd0);
            tick();
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(id));
        chk("resp_s", 32'(resp_s), 32'(exp_s));
        chk("resp_flag", 32'(resp_flag), 32'(exp_f));
        chk("busy_idle", 32'(busy), 32'd0);
        tick();
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("resp_s_held", 32'(resp_s), 32'(exp_s));
    endtask

    initial begin
        int       nresp;
        int       r1cnt;
        logic     ids [4];

        rst = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        tick();
        tick();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ula_a", 32'(ula_a), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        do_op(1'b0, 8'd200, 8'd100, 3'b000, 8'd44, 1'b1);
        do_op(1'b1, 8'h0F, 8'h3C, 3'b100, 8'h33, 1'b0);
        do_op(1'b0, 8'd7, 8'd7, 3'b110, 8'd1, 1'b0);
        do_op(1'b0, 8'd7, 8'd8, 3'b110, 8'd0, 1'b0);
        do_op(1'b0, 8'd5, 8'd9, 3'b001, 8'hFC, 1'b1);
        do_op(1'b1, 8'hFF, 8'hFF, 3'b010, 8'hFF, 1'b0);

        // Back-to-back: second handshake in the same cycle as the first response.
        req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20; req0_op = 3'b000;
        #1;
        chk("b2b_ready1", 32'(req0_ready), 32'd1);
        tick();
        req0_a = 8'd30; req0_b = 8'd40; req0_op = 3'b011;
        for (int k = 0; k < 3; k++) begin
            chk("b2b_not_ready", 32'(req0_ready), 32'd0);
            tick();
        end
        chk("b2b_resp1_valid", 32'(resp_valid), 32'd1);
        chk("b2b_resp1_s", 32'(resp_s), 32'd30);
        chk("b2b_ready2", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        chk("b2b_resp2_valid", 32'(resp_valid), 32'd1);
        chk("b2b_resp2_s", 32'(resp_s), 32'd62);
        chk("b2b_resp2_flag", 32'(resp_flag), 32'd0);
        tick();

        // Reset in EXEC aborts the op.
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'b000;
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_ula_a", 32'(ula_a), 32'd0);
        chk("abort_ula_b", 32'(ula_b), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_s", 32'(resp_s), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_op(1'b0, 8'd1, 8'd2, 3'b000, 8'd3, 1'b0);

        // Both requesters held valid from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd3; req1_op = 3'b001;
        #1;
        nresp = 0;
        r1cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (req1_ready) r1cnt++;
            tick();
            if (resp_valid) begin
                if (nresp < 4) ids[nresp] = resp_id;
                chk("rr_resp_s", 32'(resp_s), resp_id ? 32'd2 : 32'd3);
                nresp++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", 32'(nresp), 32'd4);
`ifdef ULA_ESC_PRIO_FIXA_EN
        chk("rr_ready1_cnt", 32'(r1cnt), 32'd0);
        for (int i = 0; i < 4; i++) chk("rr_id", 32'(ids[i]), 32'd0);
`else
        chk("rr_ready1_cnt", 32'(r1cnt), 32'd2);
        for (int i = 0; i < 4; i++) chk("rr_id", 32'(ids[i]), 32'(i % 2));
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
